spi_regs_responder: RTL and testbench

- Synthesizable SPI responder (slave) implementing a LIS3DH-style register protocol, driven by the SoC's SPI master pins (spi_sck/spi_csn/spi_mosi/spi_miso).
- Used in simulation and on-board loopback as the far end of the SoC SPI master, in place of an external sensor.
- Holds a 64 x 8 register file. Local-side load and observe ports let the bench or other logic inject "sensor" data and watch SPI writes.

---
 rtl/spi_regs_responder.sv | 191 +++++++++++++++++++
 tb/tb_spi_regs_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regs_responder.sv
// SPI mode-3 responder with a LIS3DH-style command byte and a 64 x 8 register file.
// All SPI pins are oversampled on XCLK; local load/observe ports expose the register file.
module spi_regs_responder #(
    parameter logic [5:0] WHOAMI_ADDR = 6'h0F,
    parameter logic [7:0] WHOAMI_VAL  = 8'h33,
    parameter logic       MISO_IDLE   = 1'b0
) (
    input  logic       XCLK,
    input  logic       XRES,
    input  logic       spi_sck,
    input  logic       spi_csn,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic       ld_en,
    input  logic [5:0] ld_addr,
    input  logic [7:0] ld_data,
    output logic       wr_strobe,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 64;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t              state_q, state_d;
    logic [1:0]          sck_sync_q, csn_sync_q, mosi_sync_q;
    logic                sck_prev_q, csn_prev_q;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0]   shift_q, shift_d;
    logic                rw_q, rw_d, ms_q, ms_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
    logic                miso_q, miso_d;
    logic                wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                busy_q;
    logic                commit_c;
    logic [DATA_W-1:0]   regs_q [DEPTH];

    logic                sck_rise_c, sck_fall_c, csn_rise_c, csn_fall_c;
    logic [DATA_W-1:0]   rx_byte_c, rd_data_c;
    logic [ADDR_W-1:0]   rd_addr_c;

    // Two-flop synchronizers plus one delay stage for edge detection; idle levels on reset.
    always_ff @(posedge XCLK) begin
        if (XRES) begin
            sck_sync_q  <= 2'b11;
            csn_sync_q  <= 2'b11;
            mosi_sync_q <= 2'b00;
            sck_prev_q  <= 1'b1;
            csn_prev_q  <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], spi_sck};
            csn_sync_q  <= {csn_sync_q[0], spi_csn};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            sck_prev_q  <= sck_sync_q[1];
            csn_prev_q  <= csn_sync_q[1];
        end
    end

    assign sck_rise_c = sck_sync_q[1] & ~sck_prev_q;
    assign sck_fall_c = ~sck_sync_q[1] & sck_prev_q;
    assign csn_rise_c = csn_sync_q[1] & ~csn_prev_q;
    assign csn_fall_c = ~csn_sync_q[1] & csn_prev_q;
    assign rx_byte_c  = {shift_q, mosi_sync_q[1]};

    // During CMD the read address comes straight from the byte being completed.
    assign rd_addr_c = (state_q == CMD) ? rx_byte_c[ADDR_W-1:0] : addr_q;
    assign rd_data_c = (rd_addr_c == WHOAMI_ADDR) ? WHOAMI_VAL : regs_q[rd_addr_c];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        ms_d        = ms_q;
        addr_d      = addr_q;
        tx_sr_d     = tx_sr_q;
        miso_d      = miso_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        commit_c    = 1'b0;

        if (csn_rise_c) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = MISO_IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (csn_fall_c) begin
                        state_d   = CMD;
                        bit_cnt_d = 3'd0;
                    end
                end
                CMD: begin
                    if (sck_rise_c) begin
                        shift_d   = rx_byte_c[DATA_W-2:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = DATA;
                            rw_d    = rx_byte_c[7];
                            ms_d    = rx_byte_c[6];
                            addr_d  = rx_byte_c[ADDR_W-1:0];
                            if (rx_byte_c[7]) begin
                                tx_sr_d = rd_data_c;
                                if (rx_byte_c[6]) addr_d = rx_byte_c[ADDR_W-1:0] + 6'd1;
                            end
                        end
                    end
                end
                DATA: begin
                    if (sck_rise_c) begin
                        shift_d   = rx_byte_c[DATA_W-2:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (ms_q) addr_d = addr_q + 6'd1;
                            if (rw_q) begin
                                tx_sr_d = rd_data_c;
                            end else begin
                                commit_c    = 1'b1;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = addr_q;
                                wr_data_d   = rx_byte_c;
                            end
                        end
                    end else if (sck_fall_c && rw_q) begin
                        miso_d  = tx_sr_q[7];
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge XCLK) begin
        if (XRES) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            ms_q        <= 1'b0;
            addr_q      <= '0;
            tx_sr_q     <= '0;
            miso_q      <= MISO_IDLE;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            ms_q        <= ms_d;
            addr_q      <= addr_d;
            tx_sr_q     <= tx_sr_d;
            miso_q      <= miso_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    // Register file: an SPI commit takes priority over a local load to the same address.
    always_ff @(posedge XCLK) begin
        if (XRES) begin
            regs_q <= '{default: '0};
        end else begin
            if (ld_en && (ld_addr != WHOAMI_ADDR) && !(commit_c && (ld_addr == addr_q)))
                regs_q[ld_addr] <= ld_data;
            if (commit_c && (addr_q != WHOAMI_ADDR))
                regs_q[addr_q] <= rx_byte_c;
        end
    end

    assign spi_miso  = miso_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_regs_responder.sv
// Randomized bench for spi_regs_responder: an SPI mode-3 master driver checked
// against an array model of the register file and an expected write-strobe list.
module tb_spi_regs_responder;

    localparam int HALF = 8;

    logic       XCLK = 1'b0;
    logic       XRES;
    logic       spi_sck, spi_csn, spi_mosi, spi_miso;
    logic       ld_en;
    logic [5:0] ld_addr;
    logic [7:0] ld_data;
    logic       wr_strobe;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mdl [64];
    logic [13:0] got_q[$];
    logic [13:0] exp_q[$];

    spi_regs_responder dut (
        .XCLK(XCLK), .XRES(XRES),
        .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy)
    );

    always #5 XCLK = ~XCLK;

    always @(negedge XCLK) if (wr_strobe) got_q.push_back({wr_addr, wr_data});

    initial begin
        #1500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge XCLK);
    endtask

    function automatic logic [7:0] mdl_rd(input logic [5:0] a);
        return (a == 6'h0F) ? 8'h33 : mdl[a];
    endfunction

    task automatic mdl_clear();
        foreach (mdl[i]) mdl[i] = 8'h00;
    endtask

    task automatic ld(input logic [5:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        clks(1);
        ld_en = 1'b0;
        if (a != 6'h0F) mdl[a] = d;
    endtask

    // Drives n bits MSB first; with coll set, a colliding local load to 0x22 lands
    // in the same XCLK cycle the responder commits the last bit.
    task automatic spi_bits(input logic [7:0] tx, input int n, input bit coll, output logic [7:0] rx);
        rx = 8'h00;
        for (int k = 0; k < n; k++) begin
            spi_sck = 1'b0; spi_mosi = tx[7-k];
            clks(HALF);
            spi_sck = 1'b1; rx[7-k] = spi_miso;
            if (coll && k == n - 1) begin
                clks(2);
                ld_en = 1'b1; ld_addr = 6'h22; ld_data = 8'hC3;
                clks(1);
                ld_en = 1'b0;
                clks(HALF - 3);
            end else begin
                clks(HALF);
            end
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, 1'b0, rx);
    endtask

    task automatic cs_lo();
        spi_csn = 1'b0; clks(HALF);
    endtask

    task automatic cs_hi();
        spi_csn = 1'b1; clks(HALF);
    endtask

    task automatic check_strobes(input string tag);
        chk({tag, "_nstb"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_stb"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic burst_read(input string tag, input logic [5:0] a, input int n);
        logic [7:0] rx;
        logic [5:0] cur;
        cur = a;
        cs_lo();
        spi_byte({2'b11, a}, rx);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, rx);
            chk(tag, 32'(rx), 32'(mdl_rd(cur)));
            cur = cur + 6'd1;
        end
        cs_hi();
    endtask

    initial begin
        logic [7:0] rx, d;
        logic [5:0] a, cur;
        bit         rw, ms;
        int         len;

        XRES = 1'b1; spi_sck = 1'b1; spi_csn = 1'b1; spi_mosi = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        mdl_clear();
        clks(5);
        XRES = 1'b0;
        clks(5);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_miso", 32'(spi_miso), 0);
        chk("rst_stb", 32'(wr_strobe), 0);
        chk("rst_waddr", 32'(wr_addr), 0);
        chk("rst_wdata", 32'(wr_data), 0);

        // Identity register
        cs_lo();
        spi_byte(8'h8F, rx);
        chk("busy_cmd", 32'(busy), 1);
        spi_byte(8'h00, rx);
        chk("whoami", 32'(rx), 32'h33);
        cs_hi();
        chk("idle_miso", 32'(spi_miso), 0);
        check_strobes("whoami");

        // Single write then read back
        cs_lo(); spi_byte(8'h20, rx); spi_byte(8'h57, rx); cs_hi();
        mdl[6'h20] = 8'h57; exp_q.push_back({6'h20, 8'h57});
        check_strobes("wr20");
        cs_lo(); spi_byte(8'hA0, rx); spi_byte(8'h00, rx); cs_hi();
        chk("rd20", 32'(rx), 32'h57);

        // Local loads then auto-increment read
        for (int i = 0; i < 6; i++) ld(6'(6'h28 + i), 8'(8'h11 * (i + 1)));
        burst_read("burst28", 6'h28, 6);

        // Burst write wrapping 0x3F -> 0x00
        cs_lo(); spi_byte(8'h7F, rx); spi_byte(8'hAA, rx); spi_byte(8'hBB, rx); cs_hi();
        mdl[6'h3F] = 8'hAA; mdl[6'h00] = 8'hBB;
        exp_q.push_back({6'h3F, 8'hAA}); exp_q.push_back({6'h00, 8'hBB});
        check_strobes("wrap");
        burst_read("wrap_rd", 6'h3F, 2);

        // Abort a write data byte after 5 bits
        cs_lo(); spi_byte(8'h21, rx); spi_bits(8'hFF, 5, 1'b0, rx);
        chk("busy_mid", 32'(busy), 1);
        spi_csn = 1'b1; clks(4);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_miso", 32'(spi_miso), 0);
        clks(HALF);
        check_strobes("abort");
        burst_read("abort_rd", 6'h21, 1);

        // Collision: SPI commit and local load to 0x22 in one cycle
        ld(6'h23, 8'h9E);
        cs_lo(); spi_byte(8'h22, rx); spi_bits(8'h5A, 8, 1'b1, rx); cs_hi();
        mdl[6'h22] = 8'h5A;
        exp_q.push_back({6'h22, 8'h5A});
        check_strobes("coll");
        burst_read("coll_rd", 6'h22, 2);

        // Randomized transactions against the model
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 1) == 1) ld(6'($urandom_range(0, 63)), 8'($urandom));
            a   = 6'($urandom_range(0, 63));
            rw  = 1'($urandom_range(0, 1));
            ms  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 4);
            cur = a;
            cs_lo();
            spi_byte({rw, ms, a}, rx);
            for (int b = 0; b < len; b++) begin
                d = 8'($urandom);
                spi_byte(d, rx);
                if (rw) begin
                    chk("rnd_rd", 32'(rx), 32'(mdl_rd(cur)));
                end else begin
                    if (cur != 6'h0F) mdl[cur] = d;
                    exp_q.push_back({cur, d});
                end
                if (ms) cur = cur + 6'd1;
            end
            cs_hi();
            check_strobes("rnd");
        end

        // Reset during the 3rd data bit of a read
        cs_lo(); spi_byte(8'hA8, rx); spi_bits(8'h00, 2, 1'b0, rx);
        spi_sck = 1'b0; clks(4);
        XRES = 1'b1; clks(3);
        spi_csn = 1'b1; spi_sck = 1'b1; clks(6);
        XRES = 1'b0; clks(4);
        mdl_clear();
        got_q.delete();
        chk("xres_busy", 32'(busy), 0);
        chk("xres_miso", 32'(spi_miso), 0);
        chk("xres_stb", 32'(wr_strobe), 0);
        burst_read("xres_rd", 6'h00, 64);
        check_strobes("xres");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
